// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter sharing one APB master command port among
//               NREQ requesters. One transaction in flight at a time; every
//               transaction returns to arbitration before the next is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int TMO  = 16
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 timeout,
    output logic                 busy,
    output logic                 m_transfer,
    output logic                 m_write,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_wdata,
    input  logic                 m_ready,
    input  logic [DW-1:0]        m_rdata
);

    localparam int IW = $clog2(NREQ);
    // Wait counter must hold the saturation value TMO+1
    localparam int CW = $clog2(TMO + 2);

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       gidx_q;
    logic [CW-1:0]       wcnt_q;
    logic                prev_ready_q;
    logic [NREQ-1:0]     gnt_q;
    logic [NREQ-1:0]     done_q;
    logic [DW-1:0]       rdata_q;
    logic                timeout_q;
    logic                m_transfer_q;
    logic                m_write_q;
    logic [AW-1:0]       m_addr_q;
    logic [DW-1:0]       m_wdata_q;

    logic                found_d;
    logic [IW-1:0]       sel_d;
    logic [IW:0]         sum_d;
    logic                write_d;
    logic [AW-1:0]       addr_d;
    logic [DW-1:0]       wdata_d;
    logic [CW-1:0]       wcnt_d;
    logic [IW-1:0]       ptr_d;

    // Rotating-priority search: first set request at or after ptr, wrapping
    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
        sum_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_d = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum_d >= (IW+1)'(NREQ)) begin
                sum_d = sum_d - (IW+1)'(NREQ);
            end
            if (!found_d && req[sum_d[IW-1:0]]) begin
                found_d = 1'b1;
                sel_d   = sum_d[IW-1:0];
            end
        end
    end

    // Select the command fields of the winning requester
    always_comb begin
        write_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_d == IW'(i)) begin
                write_d = req_write[i];
                addr_d  = req_addr[i*AW +: AW];
                wdata_d = req_wdata[i*DW +: DW];
            end
        end
    end

    // Saturating wait count and the pointer just past the current grantee
    always_comb begin
        wcnt_d = (wcnt_q == CW'(TMO + 1)) ? wcnt_q : wcnt_q + CW'(1);
        ptr_d  = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
    end

    // Transaction sequencer with all outputs registered
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q      <= S_ARB;
            ptr_q        <= '0;
            gidx_q       <= '0;
            wcnt_q       <= '0;
            prev_ready_q <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            timeout_q    <= 1'b0;
            m_transfer_q <= 1'b0;
            m_write_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            prev_ready_q <= m_ready;
            case (state_q)
                S_ARB: begin
                    done_q <= '0;
                    if (found_d) begin
                        gnt_q        <= NREQ'(1) << sel_d;
                        gidx_q       <= sel_d;
                        m_write_q    <= write_d;
                        m_addr_q     <= addr_d;
                        m_wdata_q    <= wdata_d;
                        m_transfer_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_transfer_q <= 1'b0;
                    wcnt_q       <= '0;
                    timeout_q    <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_ready && !prev_ready_q) begin
                        // Capture on the pready edge so rdata lines up with done
                        done_q <= gnt_q;
                        if (!m_write_q) begin
                            rdata_q <= m_rdata;
                        end
                        state_q <= S_CAPT;
                    end else begin
                        wcnt_q <= wcnt_d;
                        // Registered flag: rises in the (TMO+1)th wait cycle
                        timeout_q <= (wcnt_d >= CW'(TMO));
                    end
                end
                S_CAPT: begin
                    done_q    <= '0;
                    gnt_q     <= '0;
                    timeout_q <= 1'b0;
                    ptr_q     <= ptr_d;
                    state_q   <= S_ARB;
                end
                default: begin
                    state_q <= S_ARB;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != S_ARB);
    assign m_transfer = m_transfer_q;
    assign m_write    = m_write_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;

endmodule
`default_nettype wire
